// File: rtl/calc_pkg.sv
// calc_pkg: shared types and instruction-field layout for calc_engine.
//   op_e    : 2-bit opcode (ADD, SUB, MUL, DIV)
//   state_e : engine FSM state (LOAD, EXEC, DRAIN)
//   Field helpers give bit offsets in {op, a, b} as functions of W.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_EXEC  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  localparam int unsigned B_LSB = 0;

  function automatic int unsigned instr_width(input int unsigned w);
    return 2 * w + 2;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned a_lsb(input int unsigned w);
    return w;
  endfunction

endpackage

// File: rtl/calc_alu_p.sv
// calc_alu_p: combinational ALU for one calc_engine instruction.
//   op_i      : opcode
//   a_i, b_i  : W-bit unsigned operands
//   result_o  : 2W-bit zero-extended result magnitude
//   neg_o     : set for SUB when a < b
//   err_o     : divide-by-zero, or DIV when the divider is not built
// Build option: CALC_DIV_EN enables the divider for OP_DIV.
module calc_alu_p
  import calc_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  op_e            op_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] result_o,
  output logic           neg_o,
  output logic           err_o
);

  localparam int unsigned RW = 2 * W;

  logic [RW-1:0] a_x;
  logic [RW-1:0] b_x;

  assign a_x = {{W{1'b0}}, a_i};
  assign b_x = {{W{1'b0}}, b_i};

  always_comb begin
    result_o = '0;
    neg_o    = 1'b0;
    err_o    = 1'b0;
    case (op_i)
      OP_ADD: result_o = a_x + b_x;
      OP_SUB: begin
        if (a_i < b_i) begin
          neg_o    = 1'b1;
          result_o = b_x - a_x;
        end else begin
          result_o = a_x - b_x;
        end
      end
      OP_MUL: result_o = a_x * b_x;
      OP_DIV: begin
`ifdef CALC_DIV_EN
        if (b_i == '0) begin
          err_o = 1'b1;
        end else begin
          result_o = a_x / b_x;
        end
`else
        err_o = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_engine.sv
// calc_engine: loads a program of up to DEPTH instructions, then executes one
// per cycle and streams results out with valid/ready backpressure.
//   clk, reset_n            : clock, synchronous active-low reset
//   in_valid/in_ready       : instruction handshake (ready only in LOAD)
//   in_data                 : {op[2W+1:2W], a[2W-1:W], b[W-1:0]}
//   in_last                 : final instruction of a short program
//   out_valid/out_ready     : result handshake
//   out_result/neg/err/idx  : registered result fields
//   busy                    : executing or draining
//   done                    : one-cycle pulse after final result accepted
// Build option: CALC_DIV_EN (see calc_alu_p).
module calc_engine
  import calc_pkg::*;
#(
  parameter  int unsigned W     = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned IW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W+1:0] in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           out_neg,
  output logic           out_err,
  output logic [IW-1:0]  out_idx,
  output logic           busy,
  output logic           done
);

  localparam int unsigned IDW = instr_width(W);
  localparam int unsigned OPL = op_lsb(W);
  localparam int unsigned AL  = a_lsb(W);
  localparam int unsigned RW  = 2 * W;
  // Counts need one extra value so a full program length DEPTH is representable.
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_LASTSLOT = CW'(DEPTH - 1);

  logic [IDW-1:0] mem [DEPTH];

  state_e         st_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  n_q;
  logic [IW-1:0]  idx_q;
  logic           out_valid_q;
  logic [RW-1:0]  out_result_q;
  logic           out_neg_q;
  logic           out_err_q;
  logic [IW-1:0]  out_idx_q;
  logic           done_q;

  logic [IDW-1:0] instr;
  op_e            instr_op;
  logic [RW-1:0]  alu_res;
  logic           alu_neg;
  logic           alu_err;
  logic           load_fire;
  logic           load_last;
  logic           slot_free;
  logic           issue_last;

  assign in_ready   = reset_n && (st_q == ST_LOAD);
  assign load_fire  = in_valid && in_ready;
  assign load_last  = in_last || (cnt_q == C_LASTSLOT);
  assign slot_free  = !out_valid_q || out_ready;
  assign issue_last = (CW'(idx_q) == (n_q - C_ONE));
  assign instr      = mem[idx_q];
  assign instr_op   = op_e'(instr[OPL +: 2]);

  calc_alu_p #(.W(W)) u_alu (
    .op_i     (instr_op),
    .a_i      (instr[AL +: W]),
    .b_i      (instr[B_LSB +: W]),
    .result_o (alu_res),
    .neg_o    (alu_neg),
    .err_o    (alu_err)
  );

  // Program memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[cnt_q[IW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q         <= ST_LOAD;
      cnt_q        <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_neg_q    <= 1'b0;
      out_err_q    <= 1'b0;
      out_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        ST_LOAD: begin
          if (load_fire) begin
            cnt_q <= cnt_q + C_ONE;
            if (load_last) begin
              n_q   <= cnt_q + C_ONE;
              idx_q <= '0;
              st_q  <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // Issuing into a free slot also retires any result taken this cycle.
          if (slot_free) begin
            out_valid_q  <= 1'b1;
            out_result_q <= alu_res;
            out_neg_q    <= alu_neg;
            out_err_q    <= alu_err;
            out_idx_q    <= idx_q;
            idx_q        <= idx_q + IW'(1);
            if (issue_last) begin
              st_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            cnt_q       <= '0;
            st_q        <= ST_LOAD;
          end
        end
        default: st_q <= ST_LOAD;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_neg    = out_neg_q;
  assign out_err    = out_err_q;
  assign out_idx    = out_idx_q;
  assign busy       = (st_q != ST_LOAD);
  assign done       = done_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed self-checking bench for calc_engine (W=8, DEPTH=16).
module tb_calc_engine;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_neg;
  logic        out_err;
  logic [3:0]  out_idx;
  logic        busy;
  logic        done;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0]  p_op  [16];
  logic [7:0]  p_a   [16];
  logic [7:0]  p_b   [16];
  logic [15:0] e_res [16];
  logic        e_neg [16];
  logic        e_err [16];

  calc_engine #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_neg    (out_neg),
    .out_err    (out_err),
    .out_idx    (out_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic setv(input int i, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] r, input logic ng,
                      input logic er);
    p_op[i] = op; p_a[i] = a; p_b[i] = b;
    e_res[i] = r; e_neg[i] = ng; e_err[i] = er;
  endtask

  task automatic set_full;
    setv(0,  2'b00, 8'd200, 8'd100, 16'h012C, 1'b0, 1'b0);
    setv(1,  2'b01, 8'd5,   8'd9,   16'h0004, 1'b1, 1'b0);
    setv(2,  2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0);
    setv(3,  2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 1'b0);
    setv(4,  2'b01, 8'd9,   8'd5,   16'h0004, 1'b0, 1'b0);
    setv(5,  2'b10, 8'd12,  8'd10,  16'h0078, 1'b0, 1'b0);
`ifdef CALC_DIV_EN
    setv(6,  2'b11, 8'd100, 8'd7,   16'h000E, 1'b0, 1'b0);
    setv(14, 2'b11, 8'd255, 8'd1,   16'h00FF, 1'b0, 1'b0);
`else
    setv(6,  2'b11, 8'd100, 8'd7,   16'h0000, 1'b0, 1'b1);
    setv(14, 2'b11, 8'd255, 8'd1,   16'h0000, 1'b0, 1'b1);
`endif
    setv(7,  2'b11, 8'd9,   8'd0,   16'h0000, 1'b0, 1'b1);
    setv(8,  2'b00, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b0);
    setv(9,  2'b01, 8'd7,   8'd7,   16'h0000, 1'b0, 1'b0);
    setv(10, 2'b10, 8'd0,   8'd200, 16'h0000, 1'b0, 1'b0);
    setv(11, 2'b00, 8'd1,   8'd2,   16'h0003, 1'b0, 1'b0);
    setv(12, 2'b01, 8'd0,   8'd255, 16'h00FF, 1'b1, 1'b0);
    setv(13, 2'b10, 8'd16,  8'd16,  16'h0100, 1'b0, 1'b0);
    setv(15, 2'b00, 8'd128, 8'd127, 16'h00FF, 1'b0, 1'b0);
  endtask

  task automatic set_prog_a;
    setv(0, 2'b00, 8'd10, 8'd20, 16'h001E, 1'b0, 1'b0);
    setv(1, 2'b01, 8'd3,  8'd1,  16'h0002, 1'b0, 1'b0);
    setv(2, 2'b10, 8'd3,  8'd4,  16'h000C, 1'b0, 1'b0);
  endtask

  task automatic set_prog_b;
    setv(0, 2'b01, 8'd1,   8'd200, 16'h00C7, 1'b1, 1'b0);
    setv(1, 2'b00, 8'd255, 8'd1,   16'h0100, 1'b0, 1'b0);
    setv(2, 2'b10, 8'd2,   8'd128, 16'h0100, 1'b0, 1'b0);
  endtask

  // Drive n beats; called at #1 after a rising edge. With hold=1, in_valid
  // stays high afterwards with junk data.
  task automatic load_prog(input int n, input bit use_last, input bit hold);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = {p_op[i], p_a[i], p_b[i]};
      in_last  = use_last && (i == n - 1);
      for (int t = 0; t < 50 && in_ready !== 1'b1; t++) begin
        @(posedge clk); #1;
      end
      n_assert++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_ready beat %0d: in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_last = 1'b0;
    if (hold) in_data = '1;
    else      in_valid = 1'b0;
  endtask

  // Consume n results, checking order, content, hold-while-stalled, done.
  task automatic collect(input int n, input bit bp, input bit chk_timing);
    int k = 0;
    int cyc = 0;
    int extra = 0;
    int dones = 0;
    bit stalled = 1'b0;
    logic [22:0] held;
    logic [22:0] got;
    logic [22:0] exp_v;
    held = '0;
    while (cyc < 400 && extra < 3) begin
      if (done === 1'b1) begin
        dones++;
        in_valid = 1'b0;
      end
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      got = {out_valid, out_result, out_neg, out_err, out_idx};
      if (busy === 1'b1) begin
        n_assert++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_busy cyc %0d: in_ready=%b required 0", cyc, in_ready);
        end
      end
      if (stalled) begin
        n_assert++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL hold_stable cyc %0d: got %h required %h", cyc, got, held);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_assert++;
        if (k >= n) begin
          n_fail++;
          $display("FAIL extra_result: got idx %0d, required only %0d results", out_idx, n);
        end else begin
          exp_v = {1'b1, e_res[k], e_neg[k], e_err[k], 4'(k)};
          if (got !== exp_v) begin
            n_fail++;
            $display("FAIL result %0d: got {v,res,neg,err,idx}=%h required %h", k, got, exp_v);
          end
        end
        if (chk_timing) begin
          n_assert++;
          if (cyc != k + 1) begin
            n_fail++;
            $display("FAIL timing %0d: accepted at cycle %0d required %0d", k, cyc, k + 1);
          end
        end
        k++;
      end
      stalled = (out_valid === 1'b1) && (out_ready !== 1'b1);
      held = got;
      if (k >= n) extra++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    n_assert++;
    if (k != n) begin
      n_fail++;
      $display("FAIL result_count: got %0d required %0d", k, n);
    end
    n_assert++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d required 1", dones);
    end
    n_assert++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_assert++;
    if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: {in_ready,out_valid,busy,done}=%b required 0000",
               {in_ready, out_valid, busy, done});
    end
    n_assert++;
    if ({out_result, out_neg, out_err, out_idx} !== 22'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {out_result, out_neg, out_err, out_idx});
    end
    reset_n = 1'b1;
    #1;
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full_program;
    set_full();
    load_prog(16, 1'b0, 1'b0);
    collect(16, 1'b0, 1'b1);
  endtask

  task automatic test_short_program;
    set_prog_a();
    load_prog(3, 1'b1, 1'b0);
    collect(3, 1'b0, 1'b1);
    set_prog_b();
    load_prog(3, 1'b1, 1'b0);
    collect(3, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    set_full();
    load_prog(16, 1'b0, 1'b0);
    collect(16, 1'b1, 1'b0);
  endtask

  task automatic test_div;
`ifdef CALC_DIV_EN
    setv(0, 2'b11, 8'd100, 8'd7,   16'h000E, 1'b0, 1'b0);
    setv(2, 2'b11, 8'd255, 8'd255, 16'h0001, 1'b0, 1'b0);
`else
    setv(0, 2'b11, 8'd100, 8'd7,   16'h0000, 1'b0, 1'b1);
    setv(2, 2'b11, 8'd255, 8'd255, 16'h0000, 1'b0, 1'b1);
`endif
    setv(1, 2'b11, 8'd9, 8'd0, 16'h0000, 1'b0, 1'b1);
    load_prog(3, 1'b1, 1'b0);
    collect(3, 1'b0, 1'b1);
  endtask

  task automatic test_reset_exec;
    bit found = 1'b0;
    set_full();
    load_prog(16, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (out_valid === 1'b1 && out_idx === 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_assert++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_idx5: idx 5 not seen, last idx=%0d", out_idx);
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_assert++;
    if ({out_valid, busy, done, in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_state: {out_valid,busy,done,in_ready}=%b required 0000",
               {out_valid, busy, done, in_ready});
    end
    reset_n = 1'b1;
    #1;
    n_assert++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b required 1", in_ready);
    end
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      n_assert++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cyc %0d: done=%b out_valid=%b required 0 0", t, done, out_valid);
      end
    end
    set_prog_b();
    load_prog(3, 1'b1, 1'b0);
    collect(3, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back_hold;
    set_prog_a();
    load_prog(3, 1'b1, 1'b1);
    collect(3, 1'b0, 1'b1);
    n_assert++;
    if (in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: in_valid=%b required 0", in_valid);
    end
    load_prog(3, 1'b1, 1'b0);
    collect(3, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_program();
    test_short_program();
    test_backpressure();
    test_div();
    test_reset_exec();
    test_back_to_back_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
